// File: rtl/systolic_result_drain.sv
// Result drain for the 3x3 systolic array. It snapshots c00..c22 on a rising
// done_in and streams the nine words out row-major over valid/ready. It also
// keeps a wrapping frame counter and a sticky overrun flag.
module systolic_result_drain #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_in,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c02,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  input  logic [DATA_W-1:0] c12,
  input  logic [DATA_W-1:0] c20,
  input  logic [DATA_W-1:0] c21,
  input  logic [DATA_W-1:0] c22,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        m_index,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clear_overrun,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int unsigned N_WORDS  = 9;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned LAST_IDX = N_WORDS - 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_dly_q, done_dly_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    frame_count_q, frame_count_d;
  logic [DATA_W-1:0]   word_q [N_WORDS];
  logic [DATA_W-1:0]   word_d [N_WORDS];
  logic [DATA_W-1:0]   c_vec  [N_WORDS];

  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [IDX_W-1:0]    m_index_q, m_index_d;
  logic                m_last_q, m_last_d;
  logic                busy_q, busy_d;

  logic                capture_edge;
  logic                final_hs;
  logic                load;
  logic                overrun_set;

  // Gather the array results in row-major order.
  always_comb begin
    c_vec[0] = c00;
    c_vec[1] = c01;
    c_vec[2] = c02;
    c_vec[3] = c10;
    c_vec[4] = c11;
    c_vec[5] = c12;
    c_vec[6] = c20;
    c_vec[7] = c21;
    c_vec[8] = c22;
  end

  // Next-state, capture decision, overrun and registered-output decode.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    done_dly_d    = done_in;
    load          = 1'b0;
    overrun_set   = 1'b0;
    capture_edge  = done_in & ~done_dly_q;
    final_hs      = (state_q == ST_SEND) && m_ready && (idx_q == IDX_W'(LAST_IDX));

    case (state_q)
      ST_IDLE: begin
        if (capture_edge) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_ready) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            frame_count_d = frame_count_q + CNT_W'(1);
            if (capture_edge) begin
              // Back-to-back frame: reload in the cycle the old one ends.
              load  = 1'b1;
              idx_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        if (capture_edge && !final_hs) begin
          overrun_set = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // A dropped capture takes priority over a clear.
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    for (int i = 0; i < int'(N_WORDS); i++) begin
      word_d[i] = load ? c_vec[i] : word_q[i];
    end

    m_valid_d = (state_d == ST_SEND);
    busy_d    = (state_d == ST_SEND);
    m_data_d  = '0;
    m_index_d = '0;
    m_last_d  = 1'b0;
    if (state_d == ST_SEND) begin
      m_data_d  = word_d[idx_d];
      m_index_d = idx_d;
      m_last_d  = (idx_d == IDX_W'(LAST_IDX));
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      done_dly_q    <= 1'b1;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_index_q     <= '0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      done_dly_q    <= done_dly_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_index_q     <= m_index_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
    end
  end

  // Snapshot buffer; its contents do not matter after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_WORDS); i++) begin
      word_q[i] <= word_d[i];
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_index     = m_index_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: directed scenarios plus random traffic,
// all checked against a frame-level reference model.
module tb_systolic_result_drain;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              done_in;
  logic              m_ready;
  logic              clear_overrun;
  logic [DATA_W-1:0] c [9];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [3:0]        m_index;
  logic              m_last;
  logic              busy;
  logic              overrun;
  logic [CNT_W-1:0]  frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .done_in(done_in),
    .c00(c[0]), .c01(c[1]), .c02(c[2]),
    .c10(c[3]), .c11(c[4]), .c12(c[5]),
    .c20(c[6]), .c21(c[7]), .c22(c[8]),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy),
    .overrun(overrun), .clear_overrun(clear_overrun),
    .frame_count(frame_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame being sent, position within it, and counters.
  bit mv, mprev, movr, mjust_rst, started;
  int mpos, mcnt;
  int mframe [9];
  bit rise, fire, fin, acc;

  always @(posedge clk) begin
    if (rst) begin
      mv = 0; mpos = 0; mcnt = 0; movr = 0; mprev = 1;
      mjust_rst = 1; started = 1;
    end else if (started) begin
      mjust_rst = 0;
      rise = done_in && !mprev;
      fire = mv && m_ready;
      fin  = fire && (mpos == 8);
      acc  = rise && (!mv || fin);
      if (rise && !acc) movr = 1;
      else if (clear_overrun) movr = 0;
      if (fin) begin
        mcnt = (mcnt + 1) % (1 << CNT_W);
        mv = 0;
      end else if (fire) begin
        mpos++;
      end
      if (acc) begin
        for (int i = 0; i < 9; i++) mframe[i] = int'(c[i]);
        mpos = 0;
        mv = 1;
      end
      mprev = done_in;
    end
  end

  // Every-cycle comparison against the model once registers have settled.
  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("m_valid", 32'(m_valid), 32'(mv));
      chk("busy", 32'(busy), 32'(mv));
      chk("overrun", 32'(overrun), 32'(movr));
      chk("frame_count", 32'(frame_count), 32'(mcnt));
      if (mv) begin
        chk("m_data", 32'(m_data), 32'(mframe[mpos]));
        chk("m_index", 32'(m_index), 32'(mpos));
        chk("m_last", 32'(m_last), 32'(mpos == 8));
      end else begin
        chk("m_last_idle", 32'(m_last), 32'd0);
        if (mjust_rst) begin
          chk("m_data_rst", 32'(m_data), 32'd0);
          chk("m_index_rst", 32'(m_index), 32'd0);
        end
      end
    end
  end

  // Record every accepted word.
  logic [DATA_W-1:0] got [$];
  always @(posedge clk) begin
    if (!rst && m_valid === 1'b1 && m_ready === 1'b1) got.push_back(m_data);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int base);
    for (int i = 0; i < 9; i++) c[i] = DATA_W'(base + i);
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    cyc(1);
    done_in = 1'b0;
    cyc(1);
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 200 && got.size() < n; k++) cyc(1);
    chk("wait_words", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_idx(input int i);
    for (int k = 0; k < 50 && !(m_valid === 1'b1 && m_index === 4'(i)); k++) cyc(1);
    chk("wait_idx", 32'(m_valid === 1'b1 && m_index === 4'(i)), 32'd1);
  endtask

  task automatic chk_frame(input string name, input int off, input int base);
    for (int i = 0; i < 9; i++) begin
      if (off + i < got.size()) chk(name, 32'(got[off + i]), 32'(base + i));
      else chk(name, 32'hDEAD, 32'(base + i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wrap_exp [5];
    wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0; wrap_exp[4] = 1;

    rst = 1; done_in = 0; m_ready = 0; clear_overrun = 0;
    set_data(0);
    cyc(3);
    rst = 0;
    cyc(1);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);

    // Basic frame with latency check.
    set_data(1); m_ready = 1; got.delete();
    done_in = 1; cyc(1);
    chk("lat_data", 32'(m_data), 32'd1);
    chk("lat_index", 32'(m_index), 32'd0);
    done_in = 0;
    wait_words(9);
    chk_frame("basic", 0, 1);
    chk("basic_fc", 32'(frame_count), 32'd1);
    cyc(1);
    chk("basic_busy", 32'(busy), 32'd0);

    // Backpressure with ready pattern 1,0,0.
    got.delete(); m_ready = 1;
    done_in = 1; cyc(1); done_in = 0;
    for (int k = 0; k < 60 && got.size() < 9; k++) begin
      m_ready = (k % 3 == 0);
      cyc(1);
    end
    m_ready = 1; cyc(3);
    chk("bp_count", 32'(got.size()), 32'd9);
    chk_frame("bp", 0, 1);
    chk("bp_fc", 32'(frame_count), 32'd2);

    // Overrun: second rise at index 3 is dropped.
    got.delete(); set_data(1);
    pulse_done();
    wait_idx(3);
    c[0] = 16'hFFFF; done_in = 1; cyc(1); done_in = 0;
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_words(9);
    chk_frame("ovr_data", 0, 1);
    chk("ovr_fc", 32'(frame_count), 32'd3);
    clear_overrun = 1; cyc(1); clear_overrun = 0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Set and clear on the same cycle: set wins.
    got.delete(); set_data(1);
    pulse_done();
    wait_idx(2);
    done_in = 1; clear_overrun = 1; cyc(1); done_in = 0; clear_overrun = 0;
    chk("ovr_setclr", 32'(overrun), 32'd1);
    wait_words(9);
    chk("wrap_fc0", 32'(frame_count), 32'd0);
    clear_overrun = 1; cyc(1); clear_overrun = 0;
    chk("ovr_clr2", 32'(overrun), 32'd0);

    // Back-to-back: rise coincides with the index-8 handshake.
    got.delete(); set_data(1);
    pulse_done();
    wait_idx(8);
    set_data(16'h0100); done_in = 1; cyc(1); done_in = 0;
    chk("b2b_valid", 32'(m_valid), 32'd1);
    chk("b2b_index", 32'(m_index), 32'd0);
    chk("b2b_data", 32'(m_data), 32'h0100);
    chk("b2b_fc", 32'(frame_count), 32'd1);
    chk("b2b_ovr", 32'(overrun), 32'd0);
    wait_words(18);
    chk_frame("b2b_old", 0, 1);
    chk_frame("b2b_new", 9, 16'h0100);

    // Held done gives one frame.
    cyc(2); got.delete(); set_data(16'h0200);
    done_in = 1; cyc(30);
    chk("held_count", 32'(got.size()), 32'd9);

    // Reset mid-frame with done_in still high.
    done_in = 0; cyc(1); done_in = 1; cyc(1);
    wait_idx(4);
    rst = 1; cyc(1);
    chk("rst2_valid", 32'(m_valid), 32'd0);
    chk("rst2_index", 32'(m_index), 32'd0);
    chk("rst2_data", 32'(m_data), 32'd0);
    chk("rst2_last", 32'(m_last), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_fc", 32'(frame_count), 32'd0);
    rst = 0; got.delete(); cyc(10);
    chk("rst2_nostart", 32'(got.size()), 32'd0);
    done_in = 0; cyc(1); done_in = 1; cyc(1); done_in = 0;
    chk("rst2_restart", 32'(m_valid), 32'd1);
    wait_words(9);
    chk_frame("rst2_frame", 0, 16'h0200);

    // Counter wrap from a fresh reset.
    rst = 1; cyc(1); rst = 0; cyc(1);
    for (int f = 0; f < 5; f++) begin
      got.delete();
      pulse_done();
      wait_words(9);
      chk("wrap_fc", 32'(frame_count), 32'(wrap_exp[f]));
    end

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) done_in = ~done_in;
      clear_overrun = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 9; i++) c[i] = DATA_W'($urandom);
      cyc(1);
    end
    rst = 0; clear_overrun = 0; done_in = 0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
